// File: rtl/bin2bcd_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - state_t           : converter FSM states (IDLE / SHIFT / DONE)
//   - digits_for_width  : number of decimal digits needed for a w-bit unsigned
//                         value, i.e. ceil(w*log10(2)), computed exactly with
//                         integer powers of 10 (no floating point).
// -----------------------------------------------------------------------------
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Smallest d with 10^d >= 2^w. 2^w is never a power of ten for w > 0, so
    // this is exactly ceil(w*log10(2)). 80 bits covers 2^64 and 10^20.
    function automatic int digits_for_width(input int w);
        logic [79:0] pow2;
        logic [79:0] pow10;
        int          d;
        pow2  = 80'd1 << w;
        pow10 = 80'd1;
        d     = 0;
        for (int i = 0; i < 24; i++) begin
            if (pow10 < pow2) begin
                pow10 = pow10 * 80'd10;
                d     = d + 1;
            end else begin
                pow10 = pow10;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble digit correction: a BCD digit of 5 or more gets
// 3 added so that the following left shift carries correctly into the next
// decimal digit.
// Ports:
//   i_digit [3:0] : BCD digit before correction
//   o_digit [3:0] : corrected digit
// -----------------------------------------------------------------------------
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Add-3 correction for digits >= 5
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end else begin
            o_digit = i_digit;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3 / double dabble), one bit
// per clock. A word is accepted in IDLE, converted over WIDTH SHIFT cycles plus
// one terminal cycle, then held in DONE until the consumer takes it.
//
// Parameters:
//   WIDTH  : binary input width (4..64)
//   DIGITS : number of BCD digits on bcd (>= digits_for_width(WIDTH))
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : input word offered
//   in_ready  : converter idle, can accept a word
//   in        : binary input (sampled only at acceptance)
//   out_valid : result held on bcd/neg
//   out_ready : consumer accepts the result
//   bcd       : result, digit 0 at bits [3:0]
//   neg       : sign of the accepted word (signed build only, else 0)
//   busy      : conversion in progress (SHIFT state)
// Configuration:
//   BIN2BCD_SIGNED_EN : when defined, in is two's complement; the magnitude is
//                       converted and the sign is reported on neg.
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  busy
);

    // The counter has to hold WIDTH itself: it counts completed shift steps
    // and the terminal SHIFT cycle is recognised by r_cnt == WIDTH.
    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    if ((WIDTH < 4) || (WIDTH > 64)) begin : g_width_check
        $fatal(1, "bin2bcd_seq: WIDTH must be in 4..64");
    end
    if (DIGITS < digits_for_width(WIDTH)) begin : g_digits_check
        $fatal(1, "bin2bcd_seq: DIGITS too small for WIDTH");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WIDTH-1:0]      r_bin;
    logic [WIDTH-1:0]      w_load;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [4*DIGITS-1:0]   w_adj;
    logic [CW-1:0]         r_cnt;
    logic                  w_accept;
    logic                  w_last;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_busy;
    logic                  w_unused_msb;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_cnt == CNT_LAST);

    // The top bit of the corrected accumulator always shifts out; it is zero
    // whenever DIGITS is large enough, so it is intentionally dropped.
    assign w_unused_msb = w_adj[4*DIGITS-1];

`ifdef BIN2BCD_SIGNED_EN
    logic r_neg;

    // Magnitude of a two's complement word; the most negative value maps onto
    // its own bit pattern, which read unsigned is exactly 2^(WIDTH-1).
    assign w_load = in[WIDTH-1] ? (~in + WIDTH'(1)) : in;

    // Sign capture at acceptance, held for the whole conversion and result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= in[WIDTH-1];
        end else begin
            r_neg <= r_neg;
        end
    end

    assign neg = r_neg;
`else
    assign w_load = in;
    assign neg    = 1'b0;
`endif

    // One add-3 corrector per BCD digit
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_bcd[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register and registered status flags derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt == SHIFT);
        end
    end

    // Shift register, BCD accumulator and step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin <= {WIDTH{1'b0}};
            r_bcd <= {(4*DIGITS){1'b0}};
            r_cnt <= {CW{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_bin <= w_load;
                        r_bcd <= {(4*DIGITS){1'b0}};
                        r_cnt <= {CW{1'b0}};
                    end else begin
                        r_bin <= r_bin;
                        r_bcd <= r_bcd;
                        r_cnt <= r_cnt;
                    end
                end
                SHIFT: begin
                    // {bcd, bin} <<= 1 after digit correction; the terminal
                    // cycle (r_cnt == WIDTH) leaves the result untouched.
                    if (!w_last) begin
                        r_bcd <= {w_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};
                        r_bin <= {r_bin[WIDTH-2:0], 1'b0};
                        r_cnt <= r_cnt + CNT_ONE;
                    end else begin
                        r_bin <= r_bin;
                        r_bcd <= r_bcd;
                        r_cnt <= r_cnt;
                    end
                end
                default: begin
                    r_bin <= r_bin;
                    r_bcd <= r_bcd;
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign bcd       = r_bcd;

endmodule
